// File: rtl/cu_pkg.sv
// cu_pkg -- shared definitions for the control unit.
//   * opcode constants (ir[31:27])
//   * FSM state encoding (T0..T7, HALT)
//   * instruction class produced by cu_decode
//   * bit positions inside reg_enable and the one-hot bus select i
//   * ALU_ADD code used for effective-address and branch-target sums
`timescale 1ns/1ps
package cu_pkg;

  localparam int OPCODE_W = 5;
  localparam int ALU_W    = 6;

  // Opcodes
  localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_ROL  = 5'b01011;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPCODE_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPCODE_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPCODE_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPCODE_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPCODE_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPCODE_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPCODE_W-1:0] OP_BR   = 5'b10011;
  localparam logic [OPCODE_W-1:0] OP_JR   = 5'b10100;
  localparam logic [OPCODE_W-1:0] OP_IN   = 5'b10110;
  localparam logic [OPCODE_W-1:0] OP_OUT  = 5'b10111;
  localparam logic [OPCODE_W-1:0] OP_MFHI = 5'b11000;
  localparam logic [OPCODE_W-1:0] OP_MFLO = 5'b11001;
  localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

  localparam logic [ALU_W-1:0] ALU_ADD = 6'b000011;

  typedef enum logic [3:0] {
    ST_T0   = 4'd0,
    ST_T1   = 4'd1,
    ST_T2   = 4'd2,
    ST_T3   = 4'd3,
    ST_T4   = 4'd4,
    ST_T5   = 4'd5,
    ST_T6   = 4'd6,
    ST_T7   = 4'd7,
    ST_HALT = 4'd8
  } state_t;

  typedef enum logic [3:0] {
    CL_LD,
    CL_LDI,
    CL_ST,
    CL_ALU_R,    // add..rol
    CL_ALU_I,    // addi/andi/ori
    CL_UNARY,    // neg/not
    CL_MULDIV,
    CL_BR,
    CL_JR,
    CL_IN,
    CL_OUT,
    CL_MFHI,
    CL_MFLO,
    CL_NOP,
    CL_HALT,
    CL_ILLEGAL
  } op_class_t;

  // reg_enable bit positions
  localparam int EN_HI  = 16;
  localparam int EN_LO  = 17;
  localparam int EN_ZHI = 18;
  localparam int EN_ZLO = 19;
  localparam int EN_PC  = 20;
  localparam int EN_IR  = 21;
  localparam int EN_MDR = 22;
  localparam int EN_MAR = 23;
  localparam int EN_Y   = 24;

  // bus-source select bit positions (one-hot)
  localparam int SEL_HI     = 16;
  localparam int SEL_LO     = 17;
  localparam int SEL_ZHI    = 18;
  localparam int SEL_ZLO    = 19;
  localparam int SEL_PC     = 20;
  localparam int SEL_MDR    = 21;
  localparam int SEL_INPORT = 22;
  localparam int SEL_C      = 23;

  // ALU operation code for opcode-driven ALU steps: the opcode itself,
  // zero-extended to the ALU select width.
  function automatic logic [ALU_W-1:0] alu_code(input logic [OPCODE_W-1:0] opcode);
    return {1'b0, opcode};
  endfunction

endpackage

// File: rtl/cu_decode.sv
// cu_decode -- combinational opcode classifier.
// Ports:
//   opcode    in  5  ir[31:27]
//   op_class  out    instruction class driving the execute sequence
//   last_step out    final execute state of the class; the FSM leaves the
//                    instruction (to T0 or HALT) after this state
`timescale 1ns/1ps
module cu_decode
  import cu_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output op_class_t           op_class,
  output state_t              last_step
);

  always_comb begin
    op_class  = CL_ILLEGAL;
    last_step = ST_T3;
    if (opcode inside {[OP_ADD:OP_ROL]}) begin
      op_class  = CL_ALU_R;
      last_step = ST_T5;
    end else begin
      case (opcode)
        OP_LD:                   begin op_class = CL_LD;     last_step = ST_T7; end
        OP_LDI:                  begin op_class = CL_LDI;    last_step = ST_T5; end
        OP_ST:                   begin op_class = CL_ST;     last_step = ST_T7; end
        OP_ADDI, OP_ANDI, OP_ORI: begin op_class = CL_ALU_I; last_step = ST_T5; end
        OP_MUL, OP_DIV:          begin op_class = CL_MULDIV; last_step = ST_T6; end
        OP_NEG, OP_NOT:          begin op_class = CL_UNARY;  last_step = ST_T4; end
        OP_BR:                   begin op_class = CL_BR;     last_step = ST_T6; end
        OP_JR:                   op_class = CL_JR;
        OP_IN:                   op_class = CL_IN;
        OP_OUT:                  op_class = CL_OUT;
        OP_MFHI:                 op_class = CL_MFHI;
        OP_MFLO:                 op_class = CL_MFLO;
        OP_NOP:                  op_class = CL_NOP;
        OP_HALT:                 op_class = CL_HALT;
        default:                 op_class = CL_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// control_unit -- multi-cycle CPU control sequencer (T0..T7, HALT).
// Ports:
//   clk         in   1  rising-edge clock
//   clr         in   1  asynchronous active-low reset
//   ir          in  32  current IR contents (opcode in ir[31:27])
//   con_ff      in   1  branch condition flip-flop
//   stop        in   1  halt request, honoured at the end of an instruction
//   reg_enable  out 32  register load enables
//   i           out 32  one-hot bus-source select
//   ALU_Sel     out  6  ALU operation
//   read/write, incPC, Gra/Grb/Grc, Rin/Rout, BAout, conIn, out_en
//               out  1  datapath strobes
//   run         out  1  high in every state except HALT
//   err         out  1  sticky illegal-opcode flag, cleared by reset
// Outputs are decoded combinationally from the current state and ir;
// the branch write-back step additionally qualifies on con_ff.
`timescale 1ns/1ps
module control_unit
  import cu_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      ir,
  input  logic             con_ff,
  input  logic             stop,
  output logic [31:0]      reg_enable,
  output logic [31:0]      i,
  output logic [ALU_W-1:0] ALU_Sel,
  output logic             read,
  output logic             write,
  output logic             incPC,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             Rin,
  output logic             Rout,
  output logic             BAout,
  output logic             conIn,
  output logic             out_en,
  output logic             run,
  output logic             err
);

  state_t                state;
  op_class_t             op_class;
  state_t                last_step;
  logic [OPCODE_W-1:0]   opcode;
  logic [26:0]           unused_ir_bits;

  assign opcode         = ir[31:27];
  assign unused_ir_bits = ir[26:0];

  cu_decode u_decode (
    .opcode    (opcode),
    .op_class  (op_class),
    .last_step (last_step)
  );

  // Sequencer: fetch states always advance; from T3 on, the decoded
  // last_step decides when the instruction is finished.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= ST_T0;
      err   <= 1'b0;
    end else begin
      case (state)
        ST_HALT: state <= ST_HALT;
        ST_T0, ST_T1, ST_T2: state <= state_t'(state + 4'd1);
        default: begin
          if (state == last_step) begin
            if (op_class == CL_HALT) begin
              state <= ST_HALT;
            end else if (op_class == CL_ILLEGAL) begin
              state <= ST_HALT;
              err   <= 1'b1;
            end else begin
              state <= stop ? ST_HALT : ST_T0;
            end
          end else begin
            state <= state_t'(state + 4'd1);
          end
        end
      endcase
    end
  end

  // Output decode: every strobe defaults low; each state raises at most
  // one bus-select bit.
  always_comb begin
    reg_enable = '0;
    i          = '0;
    ALU_Sel    = '0;
    read       = 1'b0;
    write      = 1'b0;
    incPC      = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Grc        = 1'b0;
    Rin        = 1'b0;
    Rout       = 1'b0;
    BAout      = 1'b0;
    conIn      = 1'b0;
    out_en     = 1'b0;
    run        = (state != ST_HALT);

    case (state)
      ST_T0: begin
        i[SEL_PC]          = 1'b1;
        reg_enable[EN_MAR] = 1'b1;
        incPC              = 1'b1;
      end
      ST_T1: begin
        read               = 1'b1;
        reg_enable[EN_MDR] = 1'b1;
      end
      ST_T2: begin
        i[SEL_MDR]         = 1'b1;
        reg_enable[EN_IR]  = 1'b1;
      end
      ST_HALT: begin
      end
      default: begin
        case (op_class)
          CL_ALU_R, CL_ALU_I: begin
            case (state)
              ST_T3: begin Grb = 1'b1; Rout = 1'b1; reg_enable[EN_Y] = 1'b1; end
              ST_T4: begin
                if (op_class == CL_ALU_I) begin
                  i[SEL_C] = 1'b1;
                end else begin
                  Grc  = 1'b1;
                  Rout = 1'b1;
                end
                ALU_Sel            = alu_code(opcode);
                reg_enable[EN_ZLO] = 1'b1;
              end
              ST_T5: begin i[SEL_ZLO] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              default: begin end
            endcase
          end
          CL_UNARY: begin
            case (state)
              ST_T3: begin
                Grb = 1'b1; Rout = 1'b1;
                ALU_Sel            = alu_code(opcode);
                reg_enable[EN_ZLO] = 1'b1;
              end
              ST_T4: begin i[SEL_ZLO] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              default: begin end
            endcase
          end
          CL_MULDIV: begin
            case (state)
              ST_T3: begin Gra = 1'b1; Rout = 1'b1; reg_enable[EN_Y] = 1'b1; end
              ST_T4: begin
                Grb = 1'b1; Rout = 1'b1;
                ALU_Sel            = alu_code(opcode);
                reg_enable[EN_ZHI] = 1'b1;
                reg_enable[EN_ZLO] = 1'b1;
              end
              ST_T5: begin i[SEL_ZLO] = 1'b1; reg_enable[EN_LO] = 1'b1; end
              ST_T6: begin i[SEL_ZHI] = 1'b1; reg_enable[EN_HI] = 1'b1; end
              default: begin end
            endcase
          end
          CL_LD, CL_LDI, CL_ST: begin
            // Shared effective-address phase: Z <= (Rb or 0) + C
            case (state)
              ST_T3: begin Grb = 1'b1; BAout = 1'b1; reg_enable[EN_Y] = 1'b1; end
              ST_T4: begin
                i[SEL_C]           = 1'b1;
                ALU_Sel            = ALU_ADD;
                reg_enable[EN_ZLO] = 1'b1;
              end
              ST_T5: begin
                i[SEL_ZLO] = 1'b1;
                if (op_class == CL_LDI) begin
                  Gra = 1'b1; Rin = 1'b1;
                end else begin
                  reg_enable[EN_MAR] = 1'b1;
                end
              end
              ST_T6: begin
                reg_enable[EN_MDR] = 1'b1;
                if (op_class == CL_LD) begin
                  read = 1'b1;
                end else begin
                  // st: MDR loads Ra from the bus, not from memory
                  Gra = 1'b1; Rout = 1'b1;
                end
              end
              ST_T7: begin
                if (op_class == CL_LD) begin
                  i[SEL_MDR] = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else begin
                  write = 1'b1;
                end
              end
              default: begin end
            endcase
          end
          CL_BR: begin
            case (state)
              ST_T3: begin Gra = 1'b1; Rout = 1'b1; conIn = 1'b1; end
              ST_T4: begin i[SEL_PC] = 1'b1; reg_enable[EN_Y] = 1'b1; end
              ST_T5: begin
                i[SEL_C]           = 1'b1;
                ALU_Sel            = ALU_ADD;
                reg_enable[EN_ZLO] = 1'b1;
              end
              ST_T6: begin
                if (con_ff) begin
                  i[SEL_ZLO]        = 1'b1;
                  reg_enable[EN_PC] = 1'b1;
                end
              end
              default: begin end
            endcase
          end
          CL_JR: begin
            if (state == ST_T3) begin Gra = 1'b1; Rout = 1'b1; reg_enable[EN_PC] = 1'b1; end
          end
          CL_IN: begin
            if (state == ST_T3) begin i[SEL_INPORT] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          end
          CL_OUT: begin
            if (state == ST_T3) begin Gra = 1'b1; Rout = 1'b1; out_en = 1'b1; end
          end
          CL_MFHI: begin
            if (state == ST_T3) begin i[SEL_HI] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          end
          CL_MFLO: begin
            if (state == ST_T3) begin i[SEL_LO] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          end
          default: begin end  // nop, halt, illegal: no datapath activity
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
`timescale 1ns/1ps
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] ir;
  logic        con_ff;
  logic        stop;
  logic [31:0] reg_enable;
  logic [31:0] i;
  logic [5:0]  ALU_Sel;
  logic        read, write, incPC, Gra, Grb, Grc, Rin, Rout, BAout, conIn, out_en, run, err;

  control_unit dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .stop(stop),
    .reg_enable(reg_enable), .i(i), .ALU_Sel(ALU_Sel),
    .read(read), .write(write), .incPC(incPC),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .conIn(conIn), .out_en(out_en), .run(run), .err(err)
  );

  always #5 clk = ~clk;

  // reg_enable bits
  localparam logic [31:0] E_HI  = 32'h0001_0000;
  localparam logic [31:0] E_LO  = 32'h0002_0000;
  localparam logic [31:0] E_ZHI = 32'h0004_0000;
  localparam logic [31:0] E_ZLO = 32'h0008_0000;
  localparam logic [31:0] E_PC  = 32'h0010_0000;
  localparam logic [31:0] E_IR  = 32'h0020_0000;
  localparam logic [31:0] E_MDR = 32'h0040_0000;
  localparam logic [31:0] E_MAR = 32'h0080_0000;
  localparam logic [31:0] E_Y   = 32'h0100_0000;
  // bus-select bits
  localparam logic [31:0] S_HI  = 32'h0001_0000;
  localparam logic [31:0] S_LO  = 32'h0002_0000;
  localparam logic [31:0] S_ZHI = 32'h0004_0000;
  localparam logic [31:0] S_ZLO = 32'h0008_0000;
  localparam logic [31:0] S_PC  = 32'h0010_0000;
  localparam logic [31:0] S_MDR = 32'h0020_0000;
  localparam logic [31:0] S_INP = 32'h0040_0000;
  localparam logic [31:0] S_C   = 32'h0080_0000;
  // single-bit strobes packed as {read,write,incPC,Gra,Grb,Grc,Rin,Rout,BAout,conIn,out_en,run,err}
  localparam logic [12:0] RD   = 13'h1000;
  localparam logic [12:0] WR   = 13'h0800;
  localparam logic [12:0] INC  = 13'h0400;
  localparam logic [12:0] GRA  = 13'h0200;
  localparam logic [12:0] GRB  = 13'h0100;
  localparam logic [12:0] GRC  = 13'h0080;
  localparam logic [12:0] RIN  = 13'h0040;
  localparam logic [12:0] ROUT = 13'h0020;
  localparam logic [12:0] BA   = 13'h0010;
  localparam logic [12:0] CON  = 13'h0008;
  localparam logic [12:0] OEN  = 13'h0004;
  localparam logic [12:0] RUN  = 13'h0002;
  localparam logic [12:0] ERR  = 13'h0001;

  logic [12:0] ctl;
  assign ctl = {read, write, incPC, Gra, Grb, Grc, Rin, Rout, BAout, conIn, out_en, run, err};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Check all outputs of the current state, then advance to the next negedge.
  task automatic step(input string tag, input logic [31:0] ei, input logic [31:0] ere,
                      input logic [5:0] ealu, input logic [12:0] ectl);
    check({tag, ".i"},   i,                 ei);
    check({tag, ".en"},  reg_enable,        ere);
    check({tag, ".alu"}, {26'd0, ALU_Sel},  {26'd0, ealu});
    check({tag, ".ctl"}, {19'd0, ctl},      {19'd0, ectl});
    @(negedge clk);
  endtask

  task automatic fetch(input string tag);
    step({tag, ".T0"}, S_PC,  E_MAR, 6'd0, INC | RUN);
    step({tag, ".T1"}, 32'd0, E_MDR, 6'd0, RD | RUN);
    step({tag, ".T2"}, S_MDR, E_IR,  6'd0, RUN);
  endtask

  // Assert clr at a random point inside the current cycle, check the T0
  // outputs while it is held, and release on the next falling edge.
  task automatic do_reset(input string tag);
    #($urandom_range(1, 4));
    clr = 1'b0;
    #1;
    check({tag, ".i"},   i,               S_PC);
    check({tag, ".en"},  reg_enable,      E_MAR);
    check({tag, ".ctl"}, {19'd0, ctl},    {19'd0, INC | RUN});
    @(negedge clk);
    clr = 1'b1;
  endtask

  initial begin
    clr = 1'b1; ir = 32'd0; con_ff = 1'b0; stop = 1'b0;
    @(negedge clk);
    do_reset("rst_init");

    // add R3,R1,R2
    ir = 32'h1989_0000;
    fetch("add");
    step("add.T3", 32'd0, E_Y,   6'd0,     GRB | ROUT | RUN);
    step("add.T4", 32'd0, E_ZLO, 6'b000011, GRC | ROUT | RUN);
    step("add.T5", S_ZLO, 32'd0, 6'd0,     GRA | RIN | RUN);

    // sub: ALU code follows the opcode
    ir = 32'h2000_0000;
    fetch("sub");
    step("sub.T3", 32'd0, E_Y,   6'd0,      GRB | ROUT | RUN);
    step("sub.T4", 32'd0, E_ZLO, 6'b000100, GRC | ROUT | RUN);
    step("sub.T5", S_ZLO, 32'd0, 6'd0,      GRA | RIN | RUN);

    // addi: constant operand from C
    ir = 32'h6000_0000;
    fetch("addi");
    step("addi.T3", 32'd0, E_Y,   6'd0,      GRB | ROUT | RUN);
    step("addi.T4", S_C,   E_ZLO, 6'b001100, RUN);
    step("addi.T5", S_ZLO, 32'd0, 6'd0,      GRA | RIN | RUN);

    // neg
    ir = 32'h8800_0000;
    fetch("neg");
    step("neg.T3", 32'd0, E_ZLO, 6'b010001, GRB | ROUT | RUN);
    step("neg.T4", S_ZLO, 32'd0, 6'd0,      GRA | RIN | RUN);

    // mul
    ir = 32'h7800_0000;
    fetch("mul");
    step("mul.T3", 32'd0, E_Y,           6'd0,      GRA | ROUT | RUN);
    step("mul.T4", 32'd0, E_ZHI | E_ZLO, 6'b001111, GRB | ROUT | RUN);
    step("mul.T5", S_ZLO, E_LO,          6'd0,      RUN);
    step("mul.T6", S_ZHI, E_HI,          6'd0,      RUN);

    // ld
    ir = 32'h0080_0000;
    fetch("ld");
    step("ld.T3", 32'd0, E_Y,   6'd0,      GRB | BA | RUN);
    step("ld.T4", S_C,   E_ZLO, 6'b000011, RUN);
    step("ld.T5", S_ZLO, E_MAR, 6'd0,      RUN);
    step("ld.T6", 32'd0, E_MDR, 6'd0,      RD | RUN);
    step("ld.T7", S_MDR, 32'd0, 6'd0,      GRA | RIN | RUN);

    // st
    ir = 32'h1000_0000;
    fetch("st");
    step("st.T3", 32'd0, E_Y,   6'd0,      GRB | BA | RUN);
    step("st.T4", S_C,   E_ZLO, 6'b000011, RUN);
    step("st.T5", S_ZLO, E_MAR, 6'd0,      RUN);
    step("st.T6", 32'd0, E_MDR, 6'd0,      GRA | ROUT | RUN);
    step("st.T7", 32'd0, 32'd0, 6'd0,      WR | RUN);

    // br, condition false then true
    for (int c = 0; c < 2; c++) begin
      ir = 32'h9800_0000;
      con_ff = 1'b0;
      fetch("br");
      step("br.T3", 32'd0, 32'd0, 6'd0,      GRA | ROUT | CON | RUN);
      con_ff = (c == 1);
      step("br.T4", S_PC,  E_Y,   6'd0,      RUN);
      step("br.T5", S_C,   E_ZLO, 6'b000011, RUN);
      if (c == 0) step("br0.T6", 32'd0, 32'd0, 6'd0, RUN);
      else        step("br1.T6", S_ZLO, E_PC,  6'd0, RUN);
    end
    con_ff = 1'b0;

    // single-step instructions
    ir = 32'hA000_0000; fetch("jr");   step("jr.T3",   32'd0, E_PC,  6'd0, GRA | ROUT | RUN);
    ir = 32'hB000_0000; fetch("in");   step("in.T3",   S_INP, 32'd0, 6'd0, GRA | RIN | RUN);
    ir = 32'hB800_0000; fetch("out");  step("out.T3",  32'd0, 32'd0, 6'd0, GRA | ROUT | OEN | RUN);
    ir = 32'hC000_0000; fetch("mfhi"); step("mfhi.T3", S_HI,  32'd0, 6'd0, GRA | RIN | RUN);
    ir = 32'hC800_0000; fetch("mflo"); step("mflo.T3", S_LO,  32'd0, 6'd0, GRA | RIN | RUN);
    ir = 32'hD000_0000; fetch("nop");  step("nop.T3",  32'd0, 32'd0, 6'd0, RUN);

    // reset in the middle of a load abandons it
    ir = 32'h0080_0000;
    fetch("ldx");
    step("ldx.T3", 32'd0, E_Y,   6'd0,      GRB | BA | RUN);
    step("ldx.T4", S_C,   E_ZLO, 6'b000011, RUN);
    do_reset("rst_mid");

    // stop raised before the last step only takes effect after it
    ir = 32'h1989_0000;
    fetch("adds");
    step("adds.T3", 32'd0, E_Y, 6'd0, GRB | ROUT | RUN);
    stop = 1'b1;
    step("adds.T4", 32'd0, E_ZLO, 6'b000011, GRC | ROUT | RUN);
    step("adds.T5", S_ZLO, 32'd0, 6'd0,      GRA | RIN | RUN);
    stop = 1'b0;
    step("adds.HALT", 32'd0, 32'd0, 6'd0, 13'd0);
    do_reset("rst_stop");

    // illegal opcodes 11111 and 10101
    ir = 32'hF800_0000;
    fetch("ill31");
    step("ill31.T3", 32'd0, 32'd0, 6'd0, RUN);
    for (int k = 0; k < 3; k++) step("ill31.HALT", 32'd0, 32'd0, 6'd0, ERR);
    do_reset("rst_ill31");
    ir = 32'hA800_0000;
    fetch("ill21");
    step("ill21.T3",   32'd0, 32'd0, 6'd0, RUN);
    step("ill21.HALT", 32'd0, 32'd0, 6'd0, ERR);
    do_reset("rst_ill21");

    // halt: run stays low for 20 cycles
    ir = 32'hD800_0000;
    fetch("halt");
    step("halt.T3", 32'd0, 32'd0, 6'd0, RUN);
    for (int k = 0; k < 20; k++) step("halt.hold", 32'd0, 32'd0, 6'd0, 13'd0);
    do_reset("rst_halt");
    ir = 32'hD000_0000;
    fetch("post");
    step("post.T3", 32'd0, 32'd0, 6'd0, RUN);
    step("post.T0", S_PC,  E_MAR, 6'd0, INC | RUN);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
